// File: rtl/iob_clint_tick_gen_pkg.sv
// rtl/iob_clint_tick_gen_pkg.sv - state encodings and defaults for the CLINT tick generator
package iob_clint_tick_gen_pkg;

    localparam logic [1:0] INT = 2'd0;
    localparam logic [1:0] ACQ = 2'd1;
    localparam logic [1:0] RTC = 2'd2;

    localparam int unsigned DEF_CLK_FREQ  = 100_000_000;
    localparam int unsigned DEF_TICK_FREQ = 100_000;

    // Width of a counter that must hold 0..max_val, never narrower than 1 bit
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/iob_sync.sv
// rtl/iob_sync.sv - multi-flop synchronizer for a single asynchronous level
module iob_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            sync_q <= '0;
        end else if (cke_i) begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/iob_clint_tick_gen.sv
// rtl/iob_clint_tick_gen.sv - mtime tick source: internal divider or qualified RTC with watchdog fallback
module iob_clint_tick_gen
    import iob_clint_tick_gen_pkg::*;
#(
    parameter int unsigned CLK_FREQ    = DEF_CLK_FREQ,
    parameter int unsigned TICK_FREQ   = DEF_TICK_FREQ,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned RTC_TIMEOUT = 8192
) (
    input  logic clk_i,
    input  logic arst_n_i,
    input  logic cke_i,
    input  logic rt_clk_i,
    input  logic rtc_en_i,
    input  logic rtc_lost_clr_i,
    output logic tick_o,
    output logic tick_src_o,
    output logic rtc_lost_o
);

    localparam int unsigned DIV = CLK_FREQ / TICK_FREQ;
    localparam int unsigned DW  = cnt_width(DIV - 1);
    localparam int unsigned WW  = cnt_width(RTC_TIMEOUT);

    if (DIV < 2) begin : g_bad_div
        $error("iob_clint_tick_gen: CLK_FREQ/TICK_FREQ must be at least 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("iob_clint_tick_gen: SYNC_STAGES must be at least 2");
    end

    logic [DW-1:0] div_cnt;
    logic          div_tick;
    logic          rt_sync;
    logic          rt_prev;
    logic          rtc_rise;
    logic [WW-1:0] wd_cnt;
    logic          wd_expire;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          rise_seen;
    logic          lost_set;
    logic          tick_nxt;
    logic          tick_q;
    logic          src_q;
    logic          lost_q;

    // The divider phase is never reset by source changes, so the period survives RTC->INT
    assign div_tick = (div_cnt == DW'(DIV - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            div_cnt <= '0;
        end else if (cke_i) begin
            div_cnt <= div_tick ? '0 : div_cnt + DW'(1);
        end
    end

    iob_sync #(
        .STAGES(SYNC_STAGES)
    ) u_rt_sync (
        .clk_i   (clk_i),
        .arst_n_i(arst_n_i),
        .cke_i   (cke_i),
        .d_i     (rt_clk_i),
        .q_o     (rt_sync)
    );

    // Registered edge detect gives the SYNC_STAGES+2 edge latency from first high sample
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            rt_prev  <= 1'b0;
            rtc_rise <= 1'b0;
        end else if (cke_i) begin
            rt_prev  <= rt_sync;
            rtc_rise <= rt_sync & ~rt_prev;
        end
    end

    assign wd_expire = (state != INT) && !rtc_rise && (wd_cnt == WW'(RTC_TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wd_cnt <= '0;
        end else if (cke_i) begin
            if (state == INT || rtc_rise) begin
                wd_cnt <= '0;
            end else begin
                wd_cnt <= wd_cnt + WW'(1);
            end
        end
    end

    // Dropping rtc_en_i wins over expiry and leaves the lost flag alone
    always_comb begin
        state_nxt = state;
        lost_set  = 1'b0;
        case (state)
            INT: begin
                if (rtc_en_i) state_nxt = ACQ;
            end
            ACQ: begin
                if (!rtc_en_i) begin
                    state_nxt = INT;
                end else if (rtc_rise && rise_seen) begin
                    state_nxt = RTC;
                end else if (wd_expire) begin
                    state_nxt = INT;
                    lost_set  = 1'b1;
                end
            end
            RTC: begin
                if (!rtc_en_i) begin
                    state_nxt = INT;
                end else if (wd_expire) begin
                    state_nxt = INT;
                    lost_set  = 1'b1;
                end
            end
            default: state_nxt = INT;
        endcase
    end

    // The handover edge is consumed in ACQ, so it never produces an RTC tick
    assign tick_nxt = (state == RTC) ? rtc_rise : div_tick;

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state     <= INT;
            rise_seen <= 1'b0;
            tick_q    <= 1'b0;
            src_q     <= 1'b0;
            lost_q    <= 1'b0;
        end else if (cke_i) begin
            state  <= state_nxt;
            tick_q <= tick_nxt;
            src_q  <= (state_nxt == RTC);
            if (state == INT) begin
                rise_seen <= 1'b0;
            end else if (rtc_rise) begin
                rise_seen <= 1'b1;
            end
            if (lost_set) begin
                lost_q <= 1'b1;
            end else if (rtc_lost_clr_i) begin
                lost_q <= 1'b0;
            end
        end
    end

    // A tick held across a cke_i freeze is released once cke_i returns
    assign tick_o     = tick_q & cke_i;
    assign tick_src_o = src_q;
    assign rtc_lost_o = lost_q;

endmodule

// File: tb/tb_iob_clint_tick_gen.sv
// tb/tb_iob_clint_tick_gen.sv - self-checking bench for iob_clint_tick_gen against a behavioural model
module tb_iob_clint_tick_gen;

    localparam int CLK_FREQ  = 1000;
    localparam int TICK_FREQ = 100;
    localparam int DIV       = CLK_FREQ / TICK_FREQ;
    localparam int S         = 2;
    localparam int T         = 50;
    localparam int M_INT     = 0;
    localparam int M_ACQ     = 1;
    localparam int M_RTC     = 2;

    logic clk          = 1'b0;
    logic arst_n       = 1'b0;
    logic cke          = 1'b1;
    logic rt_clk       = 1'b0;
    logic rtc_en       = 1'b0;
    logic rtc_lost_clr = 1'b0;
    logic tick;
    logic tick_src;
    logic rtc_lost;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    bit rt_run  = 1'b0;
    bit rt_rand = 1'b0;
    int rt_hi   = 8;
    int rt_lo   = 8;

    // Reference model: edge index since reset, RTC sample history, mode, last watchdog reference edge
    bit samp [0:65535];
    int m_n;
    int m_mode;
    int m_ref;
    int m_rises;
    bit m_tick;
    bit m_src;
    bit m_lost;

    iob_clint_tick_gen #(
        .CLK_FREQ   (CLK_FREQ),
        .TICK_FREQ  (TICK_FREQ),
        .SYNC_STAGES(S),
        .RTC_TIMEOUT(T)
    ) dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .cke_i         (cke),
        .rt_clk_i      (rt_clk),
        .rtc_en_i      (rtc_en),
        .rtc_lost_clr_i(rtc_lost_clr),
        .tick_o        (tick),
        .tick_src_o    (tick_src),
        .rtc_lost_o    (rtc_lost)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_s(input int k);
        return (k < 1) ? 1'b0 : samp[k];
    endfunction

    // An RTC rise sampled at edge k reaches the control logic at edge k+S+1
    function automatic bit m_rise(input int k);
        return m_s(k - S - 1) & ~m_s(k - S - 2);
    endfunction

    function automatic bit exp_next();
        int n;
        n = m_n + 1;
        return (m_mode != M_INT) && rtc_en && !m_rise(n) && (n - m_ref == T);
    endfunction

    task automatic m_reset();
        m_n     = 0;
        m_mode  = M_INT;
        m_ref   = 0;
        m_rises = 0;
        m_tick  = 1'b0;
        m_src   = 1'b0;
        m_lost  = 1'b0;
    endtask

    task automatic m_step();
        int n;
        int old;
        bit r;
        bit expire;
        bit set_lost;
        m_n++;
        n         = m_n;
        samp[n]   = rt_clk;
        r         = m_rise(n);
        expire    = (m_mode != M_INT) && !r && (n - m_ref == T);
        old       = m_mode;
        m_tick    = (old == M_RTC) ? r : (n % DIV == 0);
        set_lost  = 1'b0;
        if (old == M_INT) begin
            if (rtc_en) begin
                m_mode  = M_ACQ;
                m_ref   = n;
                m_rises = 0;
            end
        end else if (!rtc_en) begin
            m_mode = M_INT;
        end else if (old == M_ACQ && r && m_rises == 1) begin
            m_mode = M_RTC;
        end else if (expire) begin
            m_mode   = M_INT;
            set_lost = 1'b1;
        end
        if (r && old != M_INT) m_ref = n;
        if (r && old == M_ACQ) m_rises++;
        if (set_lost) m_lost = 1'b1;
        else if (rtc_lost_clr) m_lost = 1'b0;
        m_src = (m_mode == M_RTC);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge arst_n);
            if (!arst_n) m_reset();
            else if (cke) m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on && arst_n) begin
                check("tick", 32'(m_tick & cke) == 32'(tick) ? 32'(tick) : 32'(tick), 32'(m_tick & cke));
                check("tick_src", 32'(tick_src), 32'(m_src));
                check("rtc_lost", 32'(rtc_lost), 32'(m_lost));
            end
        end
    end

    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rt_run) begin
                cnt++;
                if (cnt >= (rt_clk ? rt_hi : rt_lo)) begin
                    rt_clk = ~rt_clk;
                    cnt    = 0;
                    if (rt_rand) begin
                        rt_hi = $urandom_range(3, 12);
                        rt_lo = $urandom_range(3, 12);
                    end
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_tick(output int cyc);
        cyc = 0;
        for (int c = 1; c <= 40 && cyc == 0; c++) begin
            @(negedge clk);
            if (tick === 1'b1) cyc = c;
        end
        #1;
    endtask

    task automatic wait_expire(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 300 && !ok; c++) begin
            if (exp_next()) ok = 1'b1;
            else step();
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic clear_lost();
        if (exp_next()) step();
        rtc_lost_clr = 1'b1;
        step();
        rtc_lost_clr = 1'b0;
    endtask

    initial begin
        int cyc;
        m_reset();
        repeat (2) step();
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_src", 32'(tick_src), 32'd0);
        check("rst_lost", 32'(rtc_lost), 32'd0);

        // Internal ticking from reset release
        arst_n = 1'b1;
        chk_on = 1'b1;
        wait_tick(cyc); check("t1_first", 32'(cyc), 32'(DIV));
        wait_tick(cyc); check("t1_second", 32'(cyc), 32'(DIV));
        wait_tick(cyc); check("t1_third", 32'(cyc), 32'(DIV));

        // Acquire a 16-cycle RTC
        rt_hi  = 8;
        rt_lo  = 8;
        rt_run = 1'b1;
        rtc_en = 1'b1;
        repeat (120) step();
        check("t2_src", 32'(tick_src), 32'd1);
        wait_tick(cyc);
        wait_tick(cyc); check("t2_period", 32'(cyc), 32'd16);

        // Lose the RTC
        rt_run = 1'b0;
        repeat (70) step();
        check("t3_lost", 32'(rtc_lost), 32'd1);
        check("t3_src", 32'(tick_src), 32'd0);

        // Clear, then clear colliding with a fresh expiry
        clear_lost();
        check("t4_clr", 32'(rtc_lost), 32'd0);
        wait_expire("t4_expire_seen");
        rtc_lost_clr = 1'b1;
        step();
        rtc_lost_clr = 1'b0;
        check("t4_set_beats_clr", 32'(rtc_lost), 32'd1);

        // Asynchronous reset while running from the RTC
        clear_lost();
        rt_run = 1'b1;
        repeat (150) step();
        check("t5_src_pre", 32'(tick_src), 32'd1);
        @(posedge clk);
        #3;
        arst_n = 1'b0;
        #1;
        check("t5_rst_tick", 32'(tick), 32'd0);
        check("t5_rst_src", 32'(tick_src), 32'd0);
        check("t5_rst_lost", 32'(rtc_lost), 32'd0);
        step();
        rtc_en = 1'b0;
        rt_run = 1'b0;
        arst_n = 1'b1;
        wait_tick(cyc); check("t5_first", 32'(cyc), 32'(DIV));
        check("t5_src", 32'(tick_src), 32'd0);

        // Clock-enable freeze shifts the phase by the frozen cycles
        for (int c = 0; c < 2 * DIV && (m_n % DIV) != 3; c++) step();
        check("t6_phase_found", 32'(m_n % DIV), 32'd3);
        cke = 1'b0;
        repeat (25) step();
        cke = 1'b1;
        wait_tick(cyc); check("t6_freeze", 32'(cyc), 32'(DIV - 3));

        // Deassert in the expiry cycle: back to INT without setting lost
        rtc_en = 1'b1;
        wait_expire("t6_expire_seen");
        rtc_en = 1'b0;
        step();
        check("t6_prio_lost", 32'(rtc_lost), 32'd0);
        check("t6_prio_src", 32'(tick_src), 32'd0);

        // Randomized mix of all inputs
        rt_rand = 1'b1;
        rt_run  = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            step();
            rtc_lost_clr = ($urandom_range(0, 19) == 0);
            cke          = ($urandom_range(0, 15) != 0);
            if ($urandom_range(0, 299) == 0) rtc_en = ~rtc_en;
            if ($urandom_range(0, 299) == 0) rt_run = ~rt_run;
            if ($urandom_range(0, 1499) == 0) begin
                @(posedge clk);
                #3;
                arst_n = 1'b0;
                #1;
                check("rand_rst_tick", 32'(tick), 32'd0);
                check("rand_rst_src", 32'(tick_src), 32'd0);
                step();
                arst_n = 1'b1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/iob_clint_tick_gen.md
# iob_clint_tick_gen

Timebase tick generator sitting directly upstream of the CLINT. It produces the one-cycle `tick_o` pulse that advances `mtime`. The pulse comes from one of two sources:
- an internal clock divider (default 100 kHz), or
- an external real-time clock `rt_clk_i`, once that clock has been synchronized and qualified.

A watchdog detects loss of the RTC and falls back to the divider without dropping the timebase.

## Interface
- `CLK_FREQ`, 100000000: system clock frequency in Hz.
- `TICK_FREQ`, 100000: internal tick rate in Hz. `DIV = CLK_FREQ/TICK_FREQ` must be ≥ 2; otherwise elaboration fails.
- `SYNC_STAGES`, 2: number of synchronizer flops on `rt_clk_i` (≥ 2).
- `RTC_TIMEOUT`, 8192: number of `clk_i` cycles without an RTC rising edge before the RTC is declared lost.
- `clk_i`  in  1  system clock. One clock domain; `rt_clk_i` is only sampled.
- `arst_n_i`  in  1  reset, asynchronous, active-low.
- `cke_i`  in  1  clock enable. While low, all registers hold.
- `rt_clk_i`  in  1  external RTC, asynchronous to `clk_i`.
- `rtc_en_i`  in  1  request to use the RTC as the tick source.
- `rtc_lost_clr_i`  in  1  clears `rtc_lost_o`.
- `tick_o`  out  1  one-cycle increment pulse for `mtime`.
- `tick_src_o`  out  1  current source: 1 = RTC, 0 = divider.
- `rtc_lost_o`  out  1  sticky flag: the RTC watchdog expired.

## Operation
- **Divider:** counter `0..DIV-1`, free-running in all states. `div_tick` is asserted when the counter equals `DIV-1`, after which the counter wraps to 0.
- **Synchronizer and edge detect:** `rt_clk_i` passes through `SYNC_STAGES` flops, then a previous-value flop. `rtc_rise = sync & ~prev`.
- **Watchdog:** counter of width `$clog2(RTC_TIMEOUT+1)`.
  - Cleared on `rtc_rise` and on entry to ACQ.
  - Otherwise increments in ACQ and RTC.
  - Expires when it reaches `RTC_TIMEOUT-1` with no `rtc_rise` in that cycle.
- **FSM states:** INT, ACQ, RTC.
  - **INT:** `tick = div_tick`. Goes to ACQ when `rtc_en_i` = 1.
  - **ACQ:** `tick = div_tick`. Counts `rtc_rise` edges.
    - On the 2nd edge, goes to RTC. That edge produces no tick, so there is no double count at handover.
    - Watchdog expiry → INT and set `rtc_lost_o`.
    - `rtc_en_i` = 0 → INT.
  - **RTC:** `tick = rtc_rise`, and `div_tick` is ignored.
    - Watchdog expiry → INT and set `rtc_lost_o`.
    - `rtc_en_i` = 0 → INT.
- **Priorities:**
  - `rtc_en_i` = 0 beats watchdog expiry: go to INT and do not set the lost flag.
  - `rtc_rise` beats expiry: the watchdog clears.
  - Set of `rtc_lost_o` beats `rtc_lost_clr_i` in the same cycle.
- **`tick_src_o`:** 1 only in RTC.
- **`cke_i` = 0:** state, counters and synchronizer freeze. `tick_o` is gated to 0. A pending registered tick appears in the first cycle after `cke_i` returns to 1.

## Timing
- **Reset values:** `tick_o` = 0, `tick_src_o` = 0, `rtc_lost_o` = 0, state INT, all counters 0, synchronizer 0. Reset takes effect asynchronously on the `arst_n_i` falling edge. Release is synchronous to `clk_i`.
- **Outputs:** all are registered, and `tick_o` is high for exactly one cycle.
- **Internal source:**
  - First `tick_o` occurs `DIV` cycles after reset release.
  - Period is exactly `DIV` cycles, including across an RTC→INT transition, because the divider phase is never reset.
- **RTC source:** `tick_o` is asserted `SYNC_STAGES+2` rising `clk_i` edges after the first edge that samples `rt_clk_i` high. The RTC high and low phases must each last at least `SYNC_STAGES+1` cycles of `clk_i`.
- **Status update:** `tick_src_o` and `rtc_lost_o` update in the same cycle as the state change.
- **Reset mid-operation:** returns to INT. Any in-flight tick is discarded.

## Structure
- **Shared header `iob_clint_conf.vh`:** add the state encodings (`INT` = 2'd0, `ACQ` = 2'd1, `RTC` = 2'd2) and the default `TICK_FREQ`.
- **Sub-module `iob_sync`:** instantiate it for the `rt_clk_i` synchronizer chain, with `SYNC_STAGES` stages.
- Everything else stays in one module: divider, watchdog, FSM and output registers.

## Test plan
All scenarios use `CLK_FREQ` = 1000, `TICK_FREQ` = 100 (`DIV` = 10) and `RTC_TIMEOUT` = 50.
1. **Reset and internal ticking:** release reset with `rtc_en_i` = 0 → `tick_o` pulses at cycles 10, 20, 30, each 1 cycle wide; `tick_src_o` = 0, `rtc_lost_o` = 0.
2. **Acquire RTC:** set `rtc_en_i` = 1 with an `rt_clk_i` period of 16 cycles → `tick_src_o` = 1 after the 2nd synchronized rise. Ticks then come every 16 cycles, 4 cycles after each `rt_clk_i` rise. No extra tick occurs at handover.
3. **RTC loss:** stop `rt_clk_i` while in RTC → after 50 cycles `tick_src_o` = 0 and `rtc_lost_o` = 1. Divider ticks resume, keeping the original 10-cycle phase.
4. **Lost-flag clear:** a `rtc_lost_clr_i` pulse → `rtc_lost_o` = 0 next cycle. With clear and expiry in the same cycle → `rtc_lost_o` = 1.
5. **Asynchronous reset mid-RTC:** drive `arst_n_i` low between clock edges → all outputs are 0 immediately. After release, `tick_o` first pulses at cycle 10 and the source is the divider.
6. **Clock-enable freeze and deassert priority:**
   - Hold `cke_i` = 0 for 25 cycles → no ticks, and the next tick falls at the frozen phase plus 25 cycles.
   - Drop `rtc_en_i` in the same cycle as watchdog expiry → state INT and `rtc_lost_o` stays 0.
